// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and types for the sample-source to filter FIFO.
//   SF_DATA_WIDTH : default word width in bits
//   SF_DEPTH      : default number of storage entries (power of two)
//   SF_ADDR_WIDTH : log2(SF_DEPTH)
//   word_t        : one stored word
//   ptr_t         : read/write pointer, wraps naturally modulo depth
//   count_t       : occupancy, one bit wider than a pointer (0..depth)
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int SF_DATA_WIDTH = 16;
  localparam int SF_DEPTH      = 8;
  localparam int SF_ADDR_WIDTH = 3;

  typedef logic [SF_DATA_WIDTH-1:0] word_t;
  typedef logic [SF_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [SF_ADDR_WIDTH:0]   count_t;

  // Occupancy after one edge, given which sides were accepted.
  function automatic count_t next_count(input count_t cur, input logic wr_acc,
                                        input logic rd_acc);
    count_t res;
    res = cur;
    if (wr_acc && !rd_acc) res = cur + count_t'(1);
    else if (rd_acc && !wr_acc) res = cur - count_t'(1);
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DATA_WIDTH register array with one synchronous write port and a
// registered read port. The array itself is not reset; only the read
// register is, so data_out starts at zero and otherwise holds the last word
// read.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_addr   : write strobe and address (already gated by caller)
//   wr_data          : word to store
//   rd_en, rd_addr   : read strobe and address (already gated by caller)
//   rd_data          : registered read word
// ---------------------------------------------------------------------------
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SF_DATA_WIDTH,
  parameter int DEPTH      = SF_DEPTH,
  parameter int ADDR_WIDTH = SF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is written only; no reset so it maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register holds its value whenever no read is accepted.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock 8 x 16 FIFO between the sample source and the filter
// datapath. Writes and reads are each qualified by a chip select and an
// enable; the read data is registered (one cycle latency).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_cs, wr_en: write chip select / enable
//   data_in     : write word
//   rd_cs, rd_en: read chip select / enable
//   data_out    : registered read word, holds last word read
//   empty, full : status derived from the registered occupancy count
// Optional feature macro: SYNC_FIFO_ERR_EN
//   adds overflow / underflow outputs, each a one-cycle pulse after a write
//   rejected because full / a read rejected because empty.
// ---------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SF_DATA_WIDTH,
  parameter int DEPTH      = SF_DEPTH,
  parameter int ADDR_WIDTH = SF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_cs,
  input  logic                  rd_cs,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_d, count_q;

  logic wr_req, rd_req;
  logic wr_acc, rd_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // Acceptance uses the pre-edge flags, so a simultaneous request at empty
  // takes only the write and at full takes only the read.
  assign wr_req = wr_cs && wr_en;
  assign rd_req = rd_cs && rd_en;
  assign wr_acc = wr_req && !full;
  assign rd_acc = rd_req && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;

  // Pulses describe the previous edge only, so they clear on their own.
  always_comb begin
    overflow_d  = wr_req && full;
    underflow_d = rd_req && empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
// Directed bench for sync_fifo. Stimulus drives one request per cycle and
// keeps a reference queue of stored words; every accepted read pushes its
// expected word onto a scoreboard, and a monitor on the falling edge pops
// and compares data_out and also checks the status flags.
// ---------------------------------------------------------------------------
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_cs, rd_cs, wr_en, rd_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        empty, full;
`ifdef SYNC_FIFO_ERR_EN
  logic        overflow, underflow;
`endif

  int total;
  int bad;

  word_t ref_q[$];
  word_t sb_q[$];
  word_t last_word;
  logic  rd_fire;
  logic  mon_en;
  logic  exp_ovf, exp_unf;

  sync_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_cs    (wr_cs),
    .rd_cs    (rd_cs),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .data_out (data_out),
    .empty    (empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%04h required=0x%04h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, then at the rising
  // edge update the reference using the pre-edge occupancy.
  task automatic applyStimulus(input logic wcs, input logic we, input logic rcs,
                               input logic re, input logic [15:0] din);
    int  cnt;
    logic wa, ra;
    @(negedge clk);
    wr_cs = wcs; wr_en = we; rd_cs = rcs; rd_en = re; data_in = din;
    @(posedge clk);
    cnt = ref_q.size();
    wa  = wcs && we && (cnt != 8);
    ra  = rcs && re && (cnt != 0);
    exp_ovf = wcs && we && (cnt == 8);
    exp_unf = rcs && re && (cnt == 0);
    if (ra) begin
      sb_q.push_back(ref_q.pop_front());
    end
    if (wa) ref_q.push_back(din);
    rd_fire = ra;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Monitor: runs half a cycle after each edge the stimulus has used.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_fire) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL sb_underrun actual=empty required=entry");
        end else begin
          last_word = sb_q.pop_front();
        end
      end
      checkOutput("data_out", data_out, last_word);
      checkOutput("empty", {15'd0, empty}, {15'd0, ref_q.size() == 0});
      checkOutput("full", {15'd0, full}, {15'd0, ref_q.size() == 8});
`ifdef SYNC_FIFO_ERR_EN
      checkOutput("overflow", {15'd0, overflow}, {15'd0, exp_ovf});
      checkOutput("underflow", {15'd0, underflow}, {15'd0, exp_unf});
`endif
    end
  end

  initial begin
    total = 0; bad = 0;
    rd_fire = 1'b0; mon_en = 1'b0; last_word = '0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    wr_cs = 0; wr_en = 0; rd_cs = 0; rd_en = 0; data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_empty", {15'd0, empty}, 16'd1);
    checkOutput("rst_full", {15'd0, full}, 16'd0);
    checkOutput("rst_data", data_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single word, then read it one cycle later.
    applyStimulus(1, 1, 1, 0, 16'h1234);
    applyStimulus(0, 0, 1, 1, 16'h0000);
    idle();

    // Fill, reject a ninth write, drain; twice for pointer wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 8; i++) applyStimulus(1, 1, 0, 0, 16'(i + pass * 16));
      applyStimulus(1, 1, 0, 0, 16'h0009);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 1, 16'h0000);
      applyStimulus(0, 0, 1, 1, 16'h0000);
    end

    // Chip select gating.
    applyStimulus(1, 1, 0, 0, 16'hA5A5);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    applyStimulus(0, 1, 0, 0, 16'hDEAD);
    applyStimulus(0, 0, 1, 1, 16'h0000);
    applyStimulus(0, 0, 1, 1, 16'h0000);

    // Simultaneous at empty: only the write lands.
    applyStimulus(1, 1, 1, 1, 16'h00E0);
    applyStimulus(0, 0, 1, 1, 16'h0000);

    // Simultaneous at four entries: count steady, order preserved.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 16'h0400 + 16'(i));
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 1, 16'h0500 + 16'(i));
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 16'h0600 + 16'(i));
    // Now full: simultaneous takes only the read.
    applyStimulus(1, 1, 1, 1, 16'hFFFF);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 1, 16'h0000);

    // Asynchronous reset mid-operation discards everything.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 16'h0700 + 16'(i));
    idle();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    ref_q.delete();
    last_word = '0;
    checkOutput("mid_rst_empty", {15'd0, empty}, 16'd1);
    checkOutput("mid_rst_data", data_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    rd_fire = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    mon_en = 1'b1;
    applyStimulus(1, 1, 0, 0, 16'h0BEE);
    applyStimulus(0, 0, 1, 1, 16'h0000);
    idle();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL sb_leftover actual=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
